// File: rtl/score_pkg.sv
// Shared types, segment constants and BCD helpers for the score display.
package score_pkg;

  typedef enum logic {
    PLAY = 1'b0,
    OVER = 1'b1
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Widest score the increment helper supports; callers zero-extend into it.
  localparam int unsigned MAX_DIGITS = 8;
  localparam int unsigned MAX_W      = 4 * MAX_DIGITS;

  // Active-low gfedcba patterns for digits 0..9 (element index = digit).
  localparam logic [9:0][6:0] SEG_LUT = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // BCD +1 over the low ndig digits; all nines saturate instead of wrapping.
  function automatic logic [MAX_W-1:0] bcd_inc_sat(input logic [MAX_W-1:0] v,
                                                   input int unsigned     ndig);
    logic [MAX_W-1:0] r;
    logic             carry;
    logic             all_nines;
    r         = v;
    carry     = 1'b1;
    all_nines = 1'b1;
    for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
      if (i < ndig) begin
        if (v[4*i +: 4] != 4'd9) all_nines = 1'b0;
        if (carry) begin
          if (v[4*i +: 4] == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = v[4*i +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    if (all_nines) r = v;
    return r;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// One BCD digit to active-low seven-segment pattern; non-decimal codes blank.
module seg7_decoder
  import score_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Table lookup for 0..9, blank otherwise
  always_comb begin
    seg_o = SEG_BLANK;
    if (bcd_i <= 4'd9) seg_o = SEG_LUT[bcd_i];
  end

endmodule

// File: rtl/score_display.sv
// Score keeper consumer: BCD score, session high score, game-over blink display.
module score_display
  import score_pkg::*;
#(
  parameter int unsigned DIGITS       = 3,
  parameter int unsigned BLINK_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  incr,
  input  logic                  stop,
  input  logic                  restart,
  output logic [4*DIGITS-1:0]   score,
  output logic [4*DIGITS-1:0]   high_score,
  output logic                  game_over,
  output logic [7*DIGITS-1:0]   hex_score,
  output logic [7*DIGITS-1:0]   hex_high
);

  localparam int unsigned W     = 4 * DIGITS;
  localparam int unsigned HW    = 7 * DIGITS;
  localparam int unsigned CNT_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_CYCLES - 1);

  state_t           state_q;
  logic [W-1:0]     score_q;
  logic [W-1:0]     high_q;
  logic [CNT_W-1:0] blink_cnt_q;
  logic             blink_phase_q;
  logic             game_over_q;
  logic [W-1:0]     score_inc;
  logic [HW-1:0]    seg_score;
  logic [HW-1:0]    seg_high;

  assign score_inc = W'(bcd_inc_sat(MAX_W'(score_q), DIGITS));

  // Game FSM, scores and blink timer; high score captured on the OVER-entry edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= PLAY;
      score_q       <= '0;
      high_q        <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      case (state_q)
        PLAY: begin
          blink_cnt_q   <= '0;
          blink_phase_q <= 1'b0;
          if (stop) begin
            state_q     <= OVER;
            game_over_q <= 1'b1;
            if (score_q > high_q) high_q <= score_q;
          end else if (incr) begin
            score_q <= score_inc;
          end
        end
        OVER: begin
          if (restart) begin
            state_q       <= PLAY;
            game_over_q   <= 1'b0;
            score_q       <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
          end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= ~blink_phase_q;
          end else begin
            blink_cnt_q <= blink_cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

  // Per-digit segment decoders for both scores
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    seg7_decoder u_dec_score (
      .bcd_i (score_q[4*g +: 4]),
      .seg_o (seg_score[7*g +: 7])
    );
    seg7_decoder u_dec_high (
      .bcd_i (high_q[4*g +: 4]),
      .seg_o (seg_high[7*g +: 7])
    );
  end

  assign score      = score_q;
  assign high_score = high_q;
  assign game_over  = game_over_q;
  assign hex_score  = blink_phase_q ? {HW{1'b1}} : seg_score;
  assign hex_high   = seg_high;

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display: vector table, corner sequences, random vs model.
module tb_score_display;

  localparam int unsigned DIGITS = 3;
  localparam int unsigned BLINK  = 8;
  localparam int unsigned W      = 4 * DIGITS;
  localparam int unsigned HW     = 7 * DIGITS;

  logic          clk;
  logic          reset;
  logic          incr;
  logic          stop;
  logic          restart;
  logic [W-1:0]  score;
  logic [W-1:0]  high_score;
  logic          game_over;
  logic [HW-1:0] hex_score;
  logic [HW-1:0] hex_high;

  score_display #(
    .DIGITS       (DIGITS),
    .BLINK_CYCLES (BLINK)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .incr       (incr),
    .stop       (stop),
    .restart    (restart),
    .score      (score),
    .high_score (high_score),
    .game_over  (game_over),
    .hex_score  (hex_score),
    .hex_high   (hex_high)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: plain integers and an edge count since entering game-over
  int m_score;
  int m_high;
  bit m_over;
  int m_ovcnt;

  typedef struct {
    bit i;
    bit s;
    bit r;
    int es;
    int eh;
    bit eo;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [W-1:0] bcd_of(input int v);
    logic [W-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int k = 0; k < int'(DIGITS); k++) begin
      r[4*k +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [HW-1:0] hex_of(input int v, input bit blank);
    logic [HW-1:0] r;
    int p;
    r = '1;
    p = 1;
    if (!blank) begin
      for (int k = 0; k < int'(DIGITS); k++) begin
        r[7*k +: 7] = seg_of((v / p) % 10);
        p = p * 10;
      end
    end
    return r;
  endfunction

  function automatic bit m_blank();
    return m_over && (((m_ovcnt / int'(BLINK)) % 2) == 1);
  endfunction

  task automatic model_reset();
    m_score = 0;
    m_high  = 0;
    m_over  = 1'b0;
    m_ovcnt = 0;
  endtask

  task automatic model_step(input bit i, input bit s, input bit r);
    if (!m_over) begin
      if (s) begin
        m_over  = 1'b1;
        m_ovcnt = 0;
        if (m_score > m_high) m_high = m_score;
      end else if (i && m_score < 999) begin
        m_score = m_score + 1;
      end
    end else if (r) begin
      m_over  = 1'b0;
      m_score = 0;
    end else begin
      m_ovcnt = m_ovcnt + 1;
    end
  endtask

  // Apply one cycle of inputs; returns 1 time unit after the edge
  task automatic step(input bit i, input bit s, input bit r);
    incr    = i;
    stop    = s;
    restart = r;
    @(posedge clk);
    model_step(i, s, r);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".score"},     32'(score),      32'(bcd_of(m_score)));
    check({tag, ".high"},      32'(high_score), 32'(bcd_of(m_high)));
    check({tag, ".game_over"}, 32'(game_over),  32'(m_over));
    check({tag, ".hex_score"}, 32'(hex_score),  32'(hex_of(m_score, m_blank())));
    check({tag, ".hex_high"},  32'(hex_high),   32'(hex_of(m_high, 1'b0)));
  endtask

  task automatic do_reset();
    incr    = 1'b0;
    stop    = 1'b0;
    restart = 1'b0;
    reset   = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    check("reset.score",     32'(score),      32'h0);
    check("reset.high",      32'(high_score), 32'h0);
    check("reset.game_over", 32'(game_over),  32'h0);
    check("reset.hex_score", 32'(hex_score),  32'(hex_of(0, 1'b0)));
    check("reset.hex_high",  32'(hex_high),   32'(hex_of(0, 1'b0)));
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic add(input bit i, input bit s, input bit r, input int es, input int eh, input bit eo);
    vec_t v;
    v.i = i; v.s = s; v.r = r; v.es = es; v.eh = eh; v.eo = eo;
    tbl.push_back(v);
  endtask

  initial begin
    reset   = 1'b1;
    incr    = 1'b0;
    stop    = 1'b0;
    restart = 1'b0;
    do_reset();

    // Directed vector table from a fresh reset
    for (int k = 1; k <= 12; k++) add(1, 0, 0, k, 0, 0);
    add(0, 0, 0, 12, 0, 0);
    for (int k = 13; k <= 15; k++) add(1, 0, 0, k, 0, 0);
    add(1, 1, 0, 15, 15, 1);
    for (int k = 0; k < 5; k++) add(1, 0, 0, 15, 15, 1);
    add(0, 0, 1, 0, 15, 0);
    for (int k = 1; k <= 7; k++) add(1, 0, 0, k, 15, 0);
    add(0, 1, 0, 7, 15, 1);
    add(0, 0, 1, 0, 15, 0);

    foreach (tbl[n]) begin
      step(tbl[n].i, tbl[n].s, tbl[n].r);
      check($sformatf("vec%0d.score", n),     32'(score),      32'(bcd_of(tbl[n].es)));
      check($sformatf("vec%0d.high", n),      32'(high_score), 32'(bcd_of(tbl[n].eh)));
      check($sformatf("vec%0d.game_over", n), 32'(game_over),  32'(tbl[n].eo));
      check($sformatf("vec%0d.hex_score", n), 32'(hex_score),  32'(hex_of(tbl[n].es, 1'b0)));
      check($sformatf("vec%0d.hex_high", n),  32'(hex_high),   32'(hex_of(tbl[n].eh, 1'b0)));
      if (n == 11) begin
        check("twelve.hex_d0", 32'(hex_score[6:0]),  32'(7'b0100100));
        check("twelve.hex_d1", 32'(hex_score[13:7]), 32'(7'b1111001));
      end
    end

    // Blink timing: visible for 8 cycles after entry, blank for 8, visible again
    for (int k = 0; k < 3; k++) step(1, 0, 0);
    step(0, 1, 0);
    for (int k = 0; k < 24; k++) begin
      bit bl;
      bl = (k >= 8) && (k < 16);
      check($sformatf("blink%0d.hex_score", k), 32'(hex_score), 32'(hex_of(3, bl)));
      check($sformatf("blink%0d.hex_high", k),  32'(hex_high),  32'(hex_of(15, 1'b0)));
      step(0, 0, 0);
    end

    // Stop held through restart: one cycle of play, then game-over again
    step(0, 1, 1);
    check("restart_stop.play", 32'(game_over), 32'h0);
    check("restart_stop.score", 32'(score), 32'h0);
    step(0, 1, 0);
    check("restart_stop.over", 32'(game_over), 32'h1);
    check_model("restart_stop");

    // BCD carries and saturation
    do_reset();
    for (int k = 0; k < 9; k++) step(1, 0, 0);
    check("sat.009", 32'(score), 32'h009);
    step(1, 0, 0);
    check("sat.010", 32'(score), 32'h010);
    for (int k = 0; k < 89; k++) step(1, 0, 0);
    check("sat.099", 32'(score), 32'h099);
    step(1, 0, 0);
    check("sat.100", 32'(score), 32'h100);
    for (int k = 0; k < 899; k++) step(1, 0, 0);
    check("sat.999", 32'(score), 32'h999);
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0);
      check($sformatf("sat.hold%0d", k), 32'(score), 32'h999);
    end
    check_model("sat");
    step(0, 1, 0);
    check_model("sat_over");

    // Asynchronous reset in game-over, observed before the next edge
    step(0, 0, 1);
    step(1, 0, 0);
    step(0, 1, 0);
    check_model("pre_async");
    #2;
    reset = 1'b1;
    #1;
    check("async.game_over", 32'(game_over),  32'h0);
    check("async.score",     32'(score),      32'h0);
    check("async.high",      32'(high_score), 32'h0);
    check("async.hex_score", 32'(hex_score),  32'(hex_of(0, 1'b0)));
    check("async.hex_high",  32'(hex_high),   32'(hex_of(0, 1'b0)));
    #1;
    reset = 1'b0;
    model_reset();

    // Random stimulus against the model
    for (int k = 0; k < 3000; k++) begin
      bit ri;
      bit rs;
      bit rr;
      ri = 1'($urandom_range(0, 1));
      rs = ($urandom_range(0, 39) == 0);
      rr = ($urandom_range(0, 7) == 0);
      step(ri, rs, rr);
      check_model($sformatf("rnd%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/score_display.md
# score_display

Consumer end of the score keeper's `incr`/`stop` pulse interface.
- Accumulates the current game score as BCD and tracks the session high score.
- Freezes play on `stop` and holds a game-over state until the player restarts.
- Drives active-low seven-segment patterns for both scores, with the current score blinking while the game is over.

## Interface
Parameters:
- `DIGITS`, 3: BCD digits per score; saturation value is all nines (999).
- `BLINK_CYCLES`, 8: clock cycles per blink half-period in game-over.
  - Board builds override it, e.g. 25_000_000.

Ports:
- `clk` input 1: system clock; all state changes on posedge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `incr` input 1: one-cycle pulse, "one point scored"; every high cycle counts, no edge detection.
- `stop` input 1: collision/out-of-bounds indication; pulse or level.
- `restart` input 1: one-cycle player pulse; starts a new game from game-over.
- `score` output 4*DIGITS: current score, BCD, digit 0 in LSBs.
- `high_score` output 4*DIGITS: session high score, BCD.
- `game_over` output 1: high in OVER state.
- `hex_score` output 7*DIGITS: active-low segments for `score`, digit 0 in LSBs, segment order gfedcba.
- `hex_high` output 7*DIGITS: active-low segments for `high_score`.

## Operation
- FSM states: PLAY, OVER. Reset state is PLAY.
- Reset values: `score`=0, `high_score`=0, `game_over`=0, blink phase=0.
  - `hex_score` and `hex_high` then show "0" on every digit.
- PLAY:
  - `stop`=1: go to OVER. If `score` > `high_score`, `high_score` takes `score` on the same edge.
  - `stop`=0, `incr`=1: `score` += 1, BCD-correct (digit 9 → 0 with carry into the next digit).
  - Saturation: at all nines, `incr` leaves `score` unchanged; no wrap to 0.
  - `incr` and `stop` in the same cycle: `stop` wins and the increment is discarded.
  - `restart` is ignored.
- OVER:
  - `incr` and `stop` are ignored; `score` and `high_score` hold.
  - `restart`=1: go to PLAY, `score` cleared to 0, `high_score` kept.
  - If `stop` is still high on the cycle after restart, the FSM re-enters OVER; this is intended.
- Comparison: concatenated BCD vectors compare as unsigned binary, since BCD ordering is preserved. No conversion.
- Blink:
  - Counter counts 0..BLINK_CYCLES-1 only in OVER and toggles the phase at wrap.
  - Counter and phase clear on every entry to OVER and in PLAY.
  - While phase=1, `hex_score` is all ones (blank). `hex_high` never blanks.
- Only `high_score` survives a restart; `reset` clears it.

## Timing
- Latency: an input sampled at edge N is reflected in `score`, `high_score`, `game_over` and the hex outputs after edge N.
  - Hex outputs are combinational decodes of registered state, with no extra register.
- The high-score update and the OVER entry occur on the same edge.
- Blink: first blank after BLINK_CYCLES cycles in OVER; then alternates every BLINK_CYCLES cycles.
- Reset asserted mid-game: all outputs return to reset values immediately, independent of `clk`.

## Structure
- Shared package `score_pkg`:
  - `state_t` enum {PLAY, OVER}.
  - `localparam logic [6:0] SEG_BLANK = 7'h7F`.
  - BCD digit-to-segment constant array (0–9).
- Sub-module `seg7_decoder`: 4-bit BCD in, 7-bit active-low out; codes above 9 give blank. Instantiate DIGITS times per score.
- BCD increment with saturation is a function in `score_pkg`.

## Test plan
- Reset, then 12 `incr` pulses → `score`=0x012, `hex_score` digit 0 = "2" (7'b0100100), digit 1 = "1" (7'b1111001), `game_over`=0.
- `score`=0x009, one `incr` → 0x010. From 0x099, `incr` → 0x100. From 0x999, three `incr` → stays 0x999.
- `score`=0x015, `incr`+`stop` in the same cycle → `score`=0x015, `high_score`=0x015, `game_over`=1 one edge later.
- In OVER, `incr` for 5 cycles → no change. `hex_score` is blank from cycles 8–15 and visible from cycles 16–23 (BLINK_CYCLES=8).
- `restart` → `score`=0, `high_score`=0x015. Score 0x007 then `stop` → `high_score` stays 0x015.
- Assert `reset` asynchronously between edges while in OVER → `game_over`=0, both scores 0 before the next edge.
